conv_layer_seq: RTL and testbench

Sequencer for the conv layer datapath. It accepts a start request with layer geometry and latches it, then streams image words and 25 weight words from a 128-bit valid/ready input into the conv layer's image and weight RAM write ports. It then pulses `convStart`, counts the conv layer's output FIFO write strobes until the full output plane is emitted, and reports `done`. It sits between the top-level CNN FSM / DMA input path and the conv layer instance.

---
 rtl/conv_layer_seq_if.sv | 21 ++
 rtl/conv_layer_seq.sv | 216 +++++++++++++++++++++
 tb/tb_conv_layer_seq.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_layer_seq_if.sv
// Input word stream between the DMA input path and the conv layer sequencer.
// The source drives valid/data, the sequencer answers with ready.
interface conv_layer_seq_if #(
    parameter int DATA_W = 128
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/conv_layer_seq.sv
// Conv layer sequencer: latches layer geometry on start, streams image and
// weight words into the conv layer RAM write ports, kicks off the conv layer,
// counts its output FIFO writes and reports completion.
module conv_layer_seq #(
    parameter logic [2:0] C1_STATE  = 3'd1,
    parameter int         WGT_WORDS = 25,
    parameter int         KSIZE     = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [5:0]             cfg_W,
    input  logic [5:0]             cfg_H,
    input  logic [4:0]             cfg_C,
    conv_layer_seq_if.slave        s_in,
    output logic [5:0]             W,
    output logic [5:0]             H,
    output logic [4:0]             C,
    output logic [2:0]             cnn_state,
    output logic                   ramImage_en,
    output logic                   ramImage_we,
    output logic [9:0]             ramImage_addrW,
    output logic [127:0]           ramImage_din,
    output logic                   ramWeight_en,
    output logic                   ramWeight_we,
    output logic [4:0]             ramWeight_addrW,
    output logic [127:0]           ramWeight_din,
    output logic                   convStart,
    input  logic                   convFinish,
    input  logic                   wfifo_wen,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err,
    output logic [9:0]             out_cnt
);

    localparam logic [4:0] WGT_LAST = 5'(WGT_WORDS - 1);
    localparam logic [9:0] KM1      = 10'(KSIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_IMG,
        S_LD_WGT,
        S_CONV,
        S_DRAIN
    } state_t;

    state_t       r_state;
    logic [9:0]   r_img_addr;
    logic [4:0]   r_wgt_addr;
    logic [10:0]  r_img_words;
    logic [9:0]   r_out_words;
    logic [9:0]   r_out_cnt;
    logic         r_in_ready;
    logic         r_busy;
    logic         r_done;
    logic         r_cfg_err;
    logic         r_conv_start;
    logic [5:0]   r_W;
    logic [5:0]   r_H;
    logic [4:0]   r_C;
    logic [2:0]   r_cnn_state;

    logic         w_accept;
    logic         w_img_wr;
    logic         w_wgt_wr;
    logic         w_img_last;
    logic         w_wgt_last;
    logic         w_cfg_ok;
    logic         w_cnt_en;
    logic [10:0]  w_img_words;
    logic [9:0]   w_out_words;

    // Output word counter never runs past the expected plane size.
    function automatic logic [9:0] sat_inc(input logic [9:0] cnt, input logic [9:0] lim);
        return (cnt >= lim) ? lim : cnt + 10'd1;
    endfunction

    assign w_cfg_ok = (cfg_W >= 6'd5) && (cfg_W <= 6'd32) &&
                      (cfg_H >= 6'd5) && (cfg_H <= 6'd32) &&
                      (cfg_C != 5'd0) && (cfg_C <= 5'd16);

    // 32x32 = 1024 needs the full 11 bits; the output plane tops out at 28x28 = 784.
    assign w_img_words = {5'd0, cfg_W} * {5'd0, cfg_H};
    assign w_out_words = ({4'd0, cfg_W} - KM1) * ({4'd0, cfg_H} - KM1);

    // ready is only ever high in the load states, so accept implies a RAM write
    assign w_accept   = s_in.in_valid & r_in_ready;
    assign w_img_wr   = w_accept & (r_state == S_LD_IMG);
    assign w_wgt_wr   = w_accept & (r_state == S_LD_WGT);
    assign w_img_last = ({1'b0, r_img_addr} == (r_img_words - 11'd1));
    assign w_wgt_last = (r_wgt_addr == WGT_LAST);
    assign w_cnt_en   = wfifo_wen & ((r_state == S_CONV) || (r_state == S_DRAIN));

    // RAM writes are issued combinationally in the accept cycle; buses idle at zero.
    assign ramImage_en     = w_img_wr;
    assign ramImage_we     = w_img_wr;
    assign ramImage_addrW  = w_img_wr ? r_img_addr : 10'd0;
    assign ramImage_din    = w_img_wr ? s_in.in_data : 128'd0;
    assign ramWeight_en    = w_wgt_wr;
    assign ramWeight_we    = w_wgt_wr;
    assign ramWeight_addrW = w_wgt_wr ? r_wgt_addr : 5'd0;
    assign ramWeight_din   = w_wgt_wr ? s_in.in_data : 128'd0;

    assign s_in.in_ready = r_in_ready;
    assign busy          = r_busy;
    assign done          = r_done;
    assign cfg_err       = r_cfg_err;
    assign convStart     = r_conv_start;
    assign out_cnt       = r_out_cnt;
    assign W             = r_W;
    assign H             = r_H;
    assign C             = r_C;
    assign cnn_state     = r_cnn_state;

    // Sequencer FSM with registered status outputs; abort overrides every transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_img_addr   <= 10'd0;
            r_wgt_addr   <= 5'd0;
            r_img_words  <= 11'd0;
            r_out_words  <= 10'd0;
            r_out_cnt    <= 10'd0;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_conv_start <= 1'b0;
            r_W          <= 6'd0;
            r_H          <= 6'd0;
            r_C          <= 5'd0;
            r_cnn_state  <= 3'd0;
        end else begin
            r_done       <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_conv_start <= 1'b0;
            if (w_cnt_en) begin
                r_out_cnt <= sat_inc(r_out_cnt, r_out_words);
            end

            if (abort) begin
                r_state     <= S_IDLE;
                r_in_ready  <= 1'b0;
                r_busy      <= 1'b0;
                r_cnn_state <= 3'd0;
                r_img_addr  <= 10'd0;
                r_wgt_addr  <= 5'd0;
                r_out_cnt   <= 10'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            if (w_cfg_ok) begin
                                r_W         <= cfg_W;
                                r_H         <= cfg_H;
                                r_C         <= cfg_C;
                                r_img_words <= w_img_words;
                                r_out_words <= w_out_words;
                                r_img_addr  <= 10'd0;
                                r_wgt_addr  <= 5'd0;
                                r_out_cnt   <= 10'd0;
                                r_in_ready  <= 1'b1;
                                r_busy      <= 1'b1;
                                r_cnn_state <= C1_STATE;
                                r_state     <= S_LD_IMG;
                            end else begin
                                r_cfg_err <= 1'b1;
                            end
                        end
                    end
                    S_LD_IMG: begin
                        if (w_img_wr) begin
                            if (w_img_last) begin
                                r_img_addr <= 10'd0;
                                r_state    <= S_LD_WGT;
                            end else begin
                                r_img_addr <= r_img_addr + 10'd1;
                            end
                        end
                    end
                    S_LD_WGT: begin
                        if (w_wgt_wr) begin
                            if (w_wgt_last) begin
                                r_wgt_addr   <= 5'd0;
                                r_in_ready   <= 1'b0;
                                r_conv_start <= 1'b1;
                                r_state      <= S_CONV;
                            end else begin
                                r_wgt_addr <= r_wgt_addr + 5'd1;
                            end
                        end
                    end
                    S_CONV: begin
                        if (convFinish) begin
                            r_state <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if (r_out_cnt == r_out_words) begin
                            r_done      <= 1'b1;
                            r_busy      <= 1'b0;
                            r_cnn_state <= 3'd0;
                            r_state     <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_conv_layer_seq.sv
// Bench for conv_layer_seq: RAM writes are checked against a scoreboard of
// words pushed as they are driven; control timing is checked inline.
module tb_conv_layer_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [5:0]   cfg_W = '0;
    logic [5:0]   cfg_H = '0;
    logic [4:0]   cfg_C = '0;
    logic [5:0]   W;
    logic [5:0]   H;
    logic [4:0]   C;
    logic [2:0]   cnn_state;
    logic         ramImage_en;
    logic         ramImage_we;
    logic [9:0]   ramImage_addrW;
    logic [127:0] ramImage_din;
    logic         ramWeight_en;
    logic         ramWeight_we;
    logic [4:0]   ramWeight_addrW;
    logic [127:0] ramWeight_din;
    logic         convStart;
    logic         convFinish = 1'b0;
    logic         wfifo_wen = 1'b0;
    logic         busy;
    logic         done;
    logic         cfg_err;
    logic [9:0]   out_cnt;

    conv_layer_seq_if sif ();

    conv_layer_seq dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .abort           (abort),
        .cfg_W           (cfg_W),
        .cfg_H           (cfg_H),
        .cfg_C           (cfg_C),
        .s_in            (sif),
        .W               (W),
        .H               (H),
        .C               (C),
        .cnn_state       (cnn_state),
        .ramImage_en     (ramImage_en),
        .ramImage_we     (ramImage_we),
        .ramImage_addrW  (ramImage_addrW),
        .ramImage_din    (ramImage_din),
        .ramWeight_en    (ramWeight_en),
        .ramWeight_we    (ramWeight_we),
        .ramWeight_addrW (ramWeight_addrW),
        .ramWeight_din   (ramWeight_din),
        .convStart       (convStart),
        .convFinish      (convFinish),
        .wfifo_wen       (wfifo_wen),
        .busy            (busy),
        .done            (done),
        .cfg_err         (cfg_err),
        .out_cnt         (out_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [137:0] img_q[$];
    logic [132:0] wgt_q[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every RAM write must match the next word the bench drove.
    always @(negedge clk) begin
        logic [137:0] ei;
        logic [132:0] ew;
        if (ramImage_en) begin
            if (img_q.size() == 0) begin
                chk("img_unexpected_wr", ramImage_en, 0);
            end else begin
                ei = img_q.pop_front();
                chk("img_addr", ramImage_addrW, ei[137:128]);
                chk("img_din", ramImage_din, ei[127:0]);
                chk("img_we", ramImage_we, 1);
            end
        end
        if (ramWeight_en) begin
            if (wgt_q.size() == 0) begin
                chk("wgt_unexpected_wr", ramWeight_en, 0);
            end else begin
                ew = wgt_q.pop_front();
                chk("wgt_addr", ramWeight_addrW, ew[132:128]);
                chk("wgt_din", ramWeight_din, ew[127:0]);
                chk("wgt_we", ramWeight_we, 1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_start(input logic [5:0] w, input logic [5:0] h, input logic [4:0] c, input bit ok);
        start = 1'b1;
        cfg_W = w;
        cfg_H = h;
        cfg_C = c;
        tick();
        start = 1'b0;
        if (ok) begin
            chk("start_busy", busy, 1);
            chk("start_ready", sif.in_ready, 1);
            chk("start_state", cnn_state, 3'd1);
            chk("start_W", W, w);
            chk("start_H", H, h);
            chk("start_C", C, c);
            chk("start_cnt", out_cnt, 0);
        end else begin
            chk("cerr_pulse", cfg_err, 1);
            chk("cerr_busy", busy, 0);
            chk("cerr_ready", sif.in_ready, 0);
            tick();
            chk("cerr_single", cfg_err, 0);
            chk("cerr_busy2", busy, 0);
        end
    endtask

    task automatic load_img(input int n, input bit gap, input int abort_at);
        logic [127:0] d;
        for (int i = 0; i < n; i++) begin
            d = rnd128();
            sif.in_valid = 1'b1;
            sif.in_data  = d;
            img_q.push_back({10'(i), d});
            if (i == abort_at) abort = 1'b1;
            tick();
            abort = 1'b0;
            if (i == abort_at) break;
            if (gap) begin
                sif.in_valid = 1'b0;
                sif.in_data  = rnd128();
                tick();
            end
        end
        sif.in_valid = 1'b0;
    endtask

    task automatic load_wgt(input int start_at);
        logic [127:0] d;
        for (int i = 0; i < 25; i++) begin
            d = rnd128();
            sif.in_valid = 1'b1;
            sif.in_data  = d;
            wgt_q.push_back({5'(i), d});
            if (i == start_at) begin
                start = 1'b1;
                cfg_W = 6'd20;
                cfg_H = 6'd20;
                cfg_C = 5'd9;
            end
            tick();
            start = 1'b0;
        end
        sif.in_valid = 1'b0;
        chk("convstart_pulse", convStart, 1);
        chk("ld_ready_low", sif.in_ready, 0);
        chk("img_q_drained", img_q.size(), 0);
        chk("wgt_q_drained", wgt_q.size(), 0);
    endtask

    // Finish with the final strobe in the same cycle, then expect done two cycles later.
    task automatic finish_and_done(input bit strobe, input logic [9:0] exp_cnt);
        convFinish = 1'b1;
        wfifo_wen  = strobe;
        tick();
        convFinish = 1'b0;
        wfifo_wen  = 1'b0;
        chk("drain_no_done", done, 0);
        chk("drain_busy", busy, 1);
        chk("drain_cnt", out_cnt, exp_cnt);
        tick();
        chk("done_pulse", done, 1);
        chk("done_busy_low", busy, 0);
        chk("done_state", cnn_state, 0);
        chk("done_cnt", out_cnt, exp_cnt);
        tick();
        chk("done_single", done, 0);
    endtask

    initial begin
        sif.in_valid = 1'b0;
        sif.in_data  = '0;

        // reset values
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_ready", sif.in_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_convstart", convStart, 0);
        chk("rst_img_en", ramImage_en, 0);
        chk("rst_wgt_en", ramWeight_en, 0);
        chk("rst_cnt", out_cnt, 0);
        chk("rst_whc", {W, H, C}, 0);
        chk("rst_state", cnn_state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 8x8x3 back-to-back load, 16 outputs
        do_start(6'd8, 6'd8, 5'd3, 1'b1);
        load_img(64, 1'b0, -1);
        load_wgt(-1);
        for (int i = 0; i < 15; i++) begin
            wfifo_wen = 1'b1;
            tick();
            if (i == 0) chk("convstart_single", convStart, 0);
        end
        wfifo_wen = 1'b0;
        chk("conv_cnt15", out_cnt, 15);
        finish_and_done(1'b1, 10'd16);

        // illegal configurations, with input offered
        sif.in_valid = 1'b1;
        sif.in_data  = rnd128();
        do_start(6'd4, 6'd8, 5'd3, 1'b0);
        do_start(6'd8, 6'd8, 5'd0, 1'b0);
        do_start(6'd8, 6'd8, 5'd17, 1'b0);
        do_start(6'd8, 6'd33, 5'd3, 1'b0);
        sif.in_valid = 1'b0;

        // abort during the image load
        do_start(6'd8, 6'd8, 5'd3, 1'b1);
        load_img(64, 1'b0, 10);
        chk("abort_busy", busy, 0);
        chk("abort_ready", sif.in_ready, 0);
        chk("abort_state", cnn_state, 0);
        chk("abort_q", img_q.size(), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_convstart", convStart, 0);
            chk("abort_no_done", done, 0);
        end

        // 5x5x7 restart at address 0, ignored starts, saturating count
        do_start(6'd5, 6'd5, 5'd7, 1'b1);
        load_img(25, 1'b0, -1);
        load_wgt(5);
        chk("ign_W", W, 6'd5);
        chk("ign_H", H, 6'd5);
        chk("ign_C", C, 5'd7);
        start = 1'b1;
        cfg_W = 6'd12;
        cfg_H = 6'd12;
        cfg_C = 5'd2;
        for (int i = 0; i < 3; i++) begin
            wfifo_wen = 1'b1;
            tick();
            start = 1'b0;
        end
        wfifo_wen = 1'b0;
        chk("ign_conv_W", W, 6'd5);
        chk("ign_conv_C", C, 5'd7);
        chk("ign_conv_busy", busy, 1);
        chk("sat_cnt", out_cnt, 1);
        finish_and_done(1'b0, 10'd1);

        // 32x32 with bubbles, 784 outputs
        do_start(6'd32, 6'd32, 5'd16, 1'b1);
        load_img(1024, 1'b1, -1);
        load_wgt(-1);
        for (int i = 0; i < 783; i++) begin
            wfifo_wen = 1'b1;
            tick();
        end
        wfifo_wen  = 1'b0;
        convFinish = 1'b1;
        tick();
        convFinish = 1'b0;
        chk("big_cnt783", out_cnt, 783);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("big_no_done", done, 0);
            chk("big_busy", busy, 1);
        end
        wfifo_wen = 1'b1;
        tick();
        wfifo_wen = 1'b0;
        chk("big_cnt784", out_cnt, 784);
        chk("big_done_early", done, 0);
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 5 && !seen; k++) begin
                tick();
                if (done) begin
                    seen = 1'b1;
                    chk("big_done_lat", k, 0);
                    chk("big_done_busy", busy, 0);
                end
            end
            if (!seen) chk("big_done_timeout", done, 1);
        end

        // async reset in DRAIN
        do_start(6'd6, 6'd6, 5'd2, 1'b1);
        load_img(36, 1'b0, -1);
        load_wgt(-1);
        convFinish = 1'b1;
        tick();
        convFinish = 1'b0;
        wfifo_wen  = 1'b1;
        tick();
        wfifo_wen  = 1'b0;
        chk("pre_rst_cnt", out_cnt, 1);
        chk("pre_rst_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_cnt", out_cnt, 0);
        chk("arst_state", cnn_state, 0);
        chk("arst_whc", {W, H, C}, 0);
        chk("arst_done", done, 0);
        chk("arst_ready", sif.in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wfifo_wen = 1'b1;
            tick();
            chk("post_rst_no_done", done, 0);
            chk("post_rst_cnt", out_cnt, 0);
        end
        wfifo_wen = 1'b0;

        chk("final_img_q", img_q.size(), 0);
        chk("final_wgt_q", wgt_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
